// File: rtl/ipm2l_sync_fifo_fwft.sv
// Single-clock FIFO: inferred synchronous RAM, level counter, optional FWFT read mode.
// Define FIFO_ERR_FLAG_EN to add err_clr plus sticky overflow/underflow flags.
module ipm2l_sync_fifo_fwft #(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned DEPTH_WIDTH      = 10,
    parameter int unsigned FWFT_MODE        = 0,
    parameter int unsigned ALMOST_FULL_NUM  = 1020,
    parameter int unsigned ALMOST_EMPTY_NUM = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   wr_en,
    output logic                   wr_full,
    output logic                   almost_full,
    input  logic                   rd_en,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   rd_empty,
    output logic                   almost_empty,
    output logic [DEPTH_WIDTH:0]   water_level
`ifdef FIFO_ERR_FLAG_EN
    ,
    input  logic                   err_clr,
    output logic                   overflow,
    output logic                   underflow
`endif
);

    localparam int unsigned DEPTH = 1 << DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0] FULL_LVL = {1'b1, {DEPTH_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FETCH,
        ST_VALID
    } state_t;

    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [DEPTH_WIDTH-1:0] wr_ptr;
    logic [DEPTH_WIDTH-1:0] rd_ptr;
    logic [DEPTH_WIDTH:0]   level;
    logic [DEPTH_WIDTH:0]   level_next;
    logic                   wr_acc;
    logic                   rd_acc;
    logic                   ram_rd;

    always_comb begin
        wr_acc     = wr_en & ~wr_full;
        rd_acc     = rd_en & ~rd_empty;
        level_next = level;
        case ({wr_acc, rd_acc})
            2'b10:   level_next = level + (DEPTH_WIDTH+1)'(1);
            2'b01:   level_next = level - (DEPTH_WIDTH+1)'(1);
            default: level_next = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            level        <= '0;
            wr_full      <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + DEPTH_WIDTH'(1);
            end
            level        <= level_next;
            wr_full      <= (level_next == FULL_LVL);
            almost_full  <= (32'(level_next) >= ALMOST_FULL_NUM);
            almost_empty <= (32'(level_next) <= ALMOST_EMPTY_NUM);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
        end else if (ram_rd) begin
            rd_ptr <= rd_ptr + DEPTH_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // rd_data doubles as the RAM output register and, in FWFT mode, the head holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (ram_rd) begin
            rd_data <= mem[rd_ptr];
        end
    end

    assign water_level = level;

    generate
        if (FWFT_MODE != 0) begin : g_fwft
            state_t state;
            state_t state_next;
            logic   ram_avail;

            // The head word (in flight or held) is part of level, so the RAM holds level minus it.
            assign ram_avail = level > (DEPTH_WIDTH+1)'(state != ST_EMPTY);

            always_ff @(posedge clk) begin
                if (rst) begin
                    state <= ST_EMPTY;
                end else begin
                    state <= state_next;
                end
            end

            // A consumed head with a successor already in RAM is refilled in the same
            // edge, so the head stays valid and back-to-back reads see no bubble.
            always_comb begin
                state_next = state;
                case (state)
                    ST_EMPTY: if (ram_avail) state_next = ST_FETCH;
                    ST_FETCH: state_next = ST_VALID;
                    ST_VALID: if (rd_en) state_next = ram_avail ? ST_VALID : ST_EMPTY;
                    default:  state_next = ST_EMPTY;
                endcase
            end

            always_comb begin
                ram_rd   = 1'b0;
                rd_empty = 1'b1;
                case (state)
                    ST_EMPTY: ram_rd = ram_avail;
                    ST_VALID: begin
                        rd_empty = 1'b0;
                        ram_rd   = rd_en & ram_avail;
                    end
                    default: begin
                        ram_rd   = 1'b0;
                        rd_empty = 1'b1;
                    end
                endcase
            end
        end else begin : g_std
            assign ram_rd = rd_acc;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_empty <= 1'b1;
                end else begin
                    rd_empty <= (level_next == '0);
                end
            end
        end
    endgenerate

`ifdef FIFO_ERR_FLAG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en & wr_full) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (rd_en & rd_empty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ipm2l_sync_fifo_fwft.sv
// Bench for ipm2l_sync_fifo_fwft: standard and FWFT instances driven by shared inputs,
// checked against queue-based reference models, a directed vector table and corner sequences.
module tb_ipm2l_sync_fifo_fwft;

    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int DEP = 16;
    localparam int AFN = 14;
    localparam int AEN = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] wr_data;

    logic          s_full, s_af, s_empty, s_ae;
    logic [DW-1:0] s_rd_data;
    logic [AW:0]   s_level;
    logic          f_full, f_af, f_empty, f_ae;
    logic [DW-1:0] f_rd_data;
    logic [AW:0]   f_level;
`ifdef FIFO_ERR_FLAG_EN
    logic          err_clr;
    logic          s_ovf, s_unf, f_ovf, f_unf;
`endif

    ipm2l_sync_fifo_fwft #(
        .DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .FWFT_MODE(0),
        .ALMOST_FULL_NUM(AFN), .ALMOST_EMPTY_NUM(AEN)
    ) u_std (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .wr_full(s_full),
        .almost_full(s_af), .rd_en(rd_en), .rd_data(s_rd_data), .rd_empty(s_empty),
        .almost_empty(s_ae), .water_level(s_level)
`ifdef FIFO_ERR_FLAG_EN
        , .err_clr(err_clr), .overflow(s_ovf), .underflow(s_unf)
`endif
    );

    ipm2l_sync_fifo_fwft #(
        .DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .FWFT_MODE(1),
        .ALMOST_FULL_NUM(AFN), .ALMOST_EMPTY_NUM(AEN)
    ) u_fwft (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .wr_full(f_full),
        .almost_full(f_af), .rd_en(rd_en), .rd_data(f_rd_data), .rd_empty(f_empty),
        .almost_empty(f_ae), .water_level(f_level)
`ifdef FIFO_ERR_FLAG_EN
        , .err_clr(err_clr), .overflow(f_ovf), .underflow(f_unf)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;

    // Standard-mode model: a queue plus the last word handed out.
    logic [DW-1:0] sq[$];
    logic [DW-1:0] s_exp_rd = '0;

    // FWFT model: each word carries its write edge; the head becomes visible two edges
    // after it is written into a FIFO with no head, or immediately when it succeeds a read head.
    typedef struct {
        logic [DW-1:0] d;
        int            t;
    } ent_t;
    ent_t fq[$];
    int   f_vis    = 0;
    bit   f_now    = 1'b0;
    bit   last_rst = 1'b0;

    typedef struct {
        logic          we;
        logic          re;
        logic [DW-1:0] wd;
        int            lvl;
        logic          full;
        logic          empty;
        logic          af;
        logic          ae;
        logic          chk_rd;
        logic [DW-1:0] rd;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit wa;
        bit ra;
        edge_n++;
        if (rst) begin
            sq.delete();
            s_exp_rd = '0;
            fq.delete();
            f_now    = 1'b0;
            last_rst = 1'b1;
        end else begin
            last_rst = 1'b0;
            wa = wr_en && (sq.size() < DEP);
            ra = rd_en && (sq.size() > 0);
            if (ra) s_exp_rd = sq.pop_front();
            if (wa) sq.push_back(wr_data);

            wa = wr_en && (fq.size() < DEP);
            ra = rd_en && f_now;
            if (ra) begin
                fq.delete(0);
                if (fq.size() > 0) f_vis = edge_n;
            end
            if (wa) begin
                fq.push_back('{d: wr_data, t: edge_n});
                if (fq.size() == 1) f_vis = edge_n + 2;
            end
            f_now = (fq.size() > 0) && (edge_n >= f_vis);
        end
    endtask

    task automatic compare_all();
        chk("s_level", 32'(s_level), 32'(sq.size()));
        chk("s_full", 32'(s_full), 32'(sq.size() == DEP));
        chk("s_empty", 32'(s_empty), 32'(sq.size() == 0));
        chk("s_af", 32'(s_af), 32'(sq.size() >= AFN));
        chk("s_ae", 32'(s_ae), 32'(sq.size() <= AEN));
        chk("s_rd_data", 32'(s_rd_data), 32'(s_exp_rd));
        chk("f_level", 32'(f_level), 32'(fq.size()));
        chk("f_full", 32'(f_full), 32'(fq.size() == DEP));
        chk("f_empty", 32'(f_empty), 32'(!f_now));
        chk("f_af", 32'(f_af), 32'(fq.size() >= AFN));
        chk("f_ae", 32'(f_ae), 32'(fq.size() <= AEN));
        if (f_now) chk("f_rd_data", 32'(f_rd_data), 32'(fq[0].d));
        else if (last_rst) chk("f_rd_data_rst", 32'(f_rd_data), 32'(0));
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_edge();
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
`ifdef FIFO_ERR_FLAG_EN
        err_clr = 1'b0;
`endif
        // Vector table: fill, overfill, drain, then steady simultaneous traffic across the wrap.
        for (int i = 0; i < 16; i++)
            tbl.push_back('{1'b1, 1'b0, 8'(i + 1), i + 1, i == 15, 1'b0, (i + 1) >= AFN, (i + 1) <= AEN, 1'b0, 8'h00});
        tbl.push_back('{1'b1, 1'b0, 8'hEE, 16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
        for (int i = 0; i < 16; i++)
            tbl.push_back('{1'b0, 1'b1, 8'h00, 15 - i, 1'b0, i == 15, (15 - i) >= AFN, (15 - i) <= AEN, 1'b1, 8'(i + 1)});
        for (int i = 0; i < 8; i++)
            tbl.push_back('{1'b1, 1'b0, 8'(8'h31 + i), i + 1, 1'b0, 1'b0, 1'b0, (i + 1) <= AEN, 1'b0, 8'h00});
        for (int k = 0; k < 20; k++)
            tbl.push_back('{1'b1, 1'b1, 8'(8'h40 + k), 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                            (k < 8) ? 8'(8'h31 + k) : 8'(8'h40 + k - 8)});

        // Reset and idle.
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        chk("rst_s_empty", 32'(s_empty), 32'(1));
        chk("rst_s_full", 32'(s_full), 32'(0));
        chk("rst_s_level", 32'(s_level), 32'(0));
        chk("rst_s_ae", 32'(s_ae), 32'(1));
        chk("rst_s_af", 32'(s_af), 32'(0));
        chk("rst_s_rd_data", 32'(s_rd_data), 32'(0));
        chk("rst_f_empty", 32'(f_empty), 32'(1));
        chk("rst_f_rd_data", 32'(f_rd_data), 32'(0));

        for (int i = 0; i < tbl.size(); i++) begin
            wr_en = tbl[i].we; rd_en = tbl[i].re; wr_data = tbl[i].wd;
            cycle();
            chk("vec_level", 32'(s_level), 32'(tbl[i].lvl));
            chk("vec_full", 32'(s_full), 32'(tbl[i].full));
            chk("vec_empty", 32'(s_empty), 32'(tbl[i].empty));
            chk("vec_af", 32'(s_af), 32'(tbl[i].af));
            chk("vec_ae", 32'(s_ae), 32'(tbl[i].ae));
            if (tbl[i].chk_rd) chk("vec_rd_data", 32'(s_rd_data), 32'(tbl[i].rd));
        end
        wr_en = 1'b0; rd_en = 1'b0;

        // FWFT latency of a single write, then a continuous read over five stored words.
        do_reset();
        wr_en = 1'b1; wr_data = 8'hA5;
        cycle();
        wr_en = 1'b0;
        chk("fwft_n_empty", 32'(f_empty), 32'(1));
        chk("std_n_empty", 32'(s_empty), 32'(0));
        cycle();
        chk("fwft_n1_empty", 32'(f_empty), 32'(1));
        cycle();
        chk("fwft_n2_empty", 32'(f_empty), 32'(0));
        chk("fwft_n2_data", 32'(f_rd_data), 32'(8'hA5));
        for (int k = 0; k < 4; k++) begin
            wr_en = 1'b1; wr_data = 8'(8'hB0 + k);
            cycle();
        end
        wr_en = 1'b0;
        cycle();
        cycle();
        rd_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            if (k < 4) begin
                chk("fwft_burst_empty", 32'(f_empty), 32'(0));
                chk("fwft_burst_data", 32'(f_rd_data), 32'(8'hB0 + k));
            end else begin
                chk("fwft_burst_end", 32'(f_empty), 32'(1));
            end
        end
        rd_en = 1'b0;

        // Reset mid-stream at level 9, then the next write is the first word read back.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h60 + i);
            cycle();
        end
        chk("mid_s_level9", 32'(s_level), 32'(9));
        chk("mid_f_level9", 32'(f_level), 32'(9));
        rst = 1'b1; wr_data = 8'h77;
        cycle();
        rst = 1'b0;
        chk("mid_s_level0", 32'(s_level), 32'(0));
        chk("mid_s_empty", 32'(s_empty), 32'(1));
        chk("mid_f_level0", 32'(f_level), 32'(0));
        chk("mid_f_empty", 32'(f_empty), 32'(1));
        wr_en = 1'b1; wr_data = 8'h33;
        cycle();
        wr_en = 1'b0; rd_en = 1'b1;
        cycle();
        chk("mid_s_first", 32'(s_rd_data), 32'(8'h33));
        rd_en = 1'b0;
        cycle();
        chk("mid_f_first_vis", 32'(f_empty), 32'(0));
        chk("mid_f_first", 32'(f_rd_data), 32'(8'h33));

`ifdef FIFO_ERR_FLAG_EN
        do_reset();
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        chk("s_unf_set", 32'(s_unf), 32'(1));
        chk("f_unf_set", 32'(f_unf), 32'(1));
        chk("s_ovf_clear", 32'(s_ovf), 32'(0));
        cycle();
        chk("s_unf_hold", 32'(s_unf), 32'(1));
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h51 + i);
            cycle();
        end
        wr_en = 1'b0;
        chk("s_ovf_set", 32'(s_ovf), 32'(1));
        chk("f_ovf_set", 32'(f_ovf), 32'(1));
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        chk("s_err_clr_o", 32'(s_ovf), 32'(0));
        chk("s_err_clr_u", 32'(s_unf), 32'(0));
        chk("f_err_clr_o", 32'(f_ovf), 32'(0));
        chk("f_err_clr_u", 32'(f_unf), 32'(0));
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        chk("err_contents", 32'(s_rd_data), 32'(8'h51));
`endif

        // Randomized traffic with phases biased toward full, toward empty, and balanced.
        do_reset();
        for (int b = 0; b < 12; b++) begin
            int wp;
            wp = (b % 3 == 0) ? 80 : ((b % 3 == 1) ? 20 : 50);
            for (int c = 0; c < 200; c++) begin
                wr_en   = ($urandom_range(0, 99) < wp);
                rd_en   = ($urandom_range(0, 99) < (100 - wp));
                wr_data = 8'($urandom);
                rst     = ($urandom_range(0, 255) == 0);
                cycle();
            end
        end
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
